// File: rtl/hpu_csr_pkg.sv
// Shared definitions for the HPU CSR block: register offsets, response codes,
// CTRL/STATUS bit positions and the AXI-Lite handshake state encoding.
package hpu_csr_pkg;

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_STATUS  = 5'h04;
    localparam logic [4:0] OFF_ADDR_I  = 5'h08;
    localparam logic [4:0] OFF_ADDR_J  = 5'h0C;
    localparam logic [4:0] OFF_RAND    = 5'h10;
    localparam logic [4:0] OFF_CORE_EN = 5'h14;
    localparam logic [4:0] OFF_SCRATCH = 5'h18;
    localparam logic [4:0] OFF_VERSION = 5'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_GEN      = 0;
    localparam int CTRL_RUN      = 1;
    localparam int CTRL_IE       = 2;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_GEN_DONE = 2;

    typedef enum logic [3:0] {
        ST_INI = 4'b0000,
        ST_AW  = 4'b0001,
        ST_W   = 4'b0010,
        ST_AWW = 4'b0011,
        ST_AR1 = 4'b0100,
        ST_AR2 = 4'b1000
    } axil_state_e;

    // Byte-lane merge of a write into an existing 32-bit register image.
    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/hpu_csr_if.sv
// AXI-Lite slave bundle for the HPU CSR block (32-bit data, ADDR_W address).
interface hpu_csr_if #(parameter int ADDR_W = 12);

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/hpu_csr_axil_slave_fsm.sv
// AXI-Lite handshake FSM: captures AW/W/AR, issues a one-cycle write strobe on
// entry to AWW and a one-cycle read strobe in AR1, and returns B/R responses.
module axil_slave_fsm
    import hpu_csr_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    hpu_csr_if.slave          s_axi,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    input  logic              rd_err,
    input  logic              wr_err
);

    axil_state_e state;
    logic        bvalid;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    assign s_axi.awready = (state == ST_INI) || (state == ST_W);
    assign s_axi.wready  = (state == ST_INI) || (state == ST_AW);
    assign s_axi.arready = (state == ST_INI);
    assign s_axi.bvalid  = bvalid;
    // wr_addr is held for the whole of AWW, so the decode is stable under bvalid.
    assign s_axi.bresp   = wr_err ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rdata   = rdata;
    assign s_axi.rresp   = rresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INI;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            rd_addr <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                ST_INI: begin
                    if (s_axi.awvalid && s_axi.wvalid) begin
                        wr_addr <= s_axi.awaddr;
                        wr_data <= s_axi.wdata;
                        wr_strb <= s_axi.wstrb;
                        wr_en   <= 1'b1;
                        bvalid  <= 1'b1;
                        state   <= ST_AWW;
                    end else if (s_axi.awvalid) begin
                        wr_addr <= s_axi.awaddr;
                        state   <= ST_AW;
                    end else if (s_axi.wvalid) begin
                        wr_data <= s_axi.wdata;
                        wr_strb <= s_axi.wstrb;
                        state   <= ST_W;
                    end else if (s_axi.arvalid) begin
                        rd_addr <= s_axi.araddr;
                        rd_en   <= 1'b1;
                        state   <= ST_AR1;
                    end
                end
                ST_AW: begin
                    if (s_axi.wvalid) begin
                        wr_data <= s_axi.wdata;
                        wr_strb <= s_axi.wstrb;
                        wr_en   <= 1'b1;
                        bvalid  <= 1'b1;
                        state   <= ST_AWW;
                    end
                end
                ST_W: begin
                    if (s_axi.awvalid) begin
                        wr_addr <= s_axi.awaddr;
                        wr_en   <= 1'b1;
                        bvalid  <= 1'b1;
                        state   <= ST_AWW;
                    end
                end
                ST_AWW: begin
                    if (s_axi.bready) begin
                        bvalid <= 1'b0;
                        state  <= ST_INI;
                    end
                end
                ST_AR1: begin
                    rdata  <= rd_data;
                    rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    rvalid <= 1'b1;
                    state  <= ST_AR2;
                end
                ST_AR2: begin
                    if (s_axi.rready) begin
                        rvalid <= 1'b0;
                        state  <= ST_INI;
                    end
                end
                default: state <= ST_INI;
            endcase
        end
    end

endmodule

// File: rtl/hpu_csr.sv
// HPU control/status register block: register file, item-memory generation
// counter, sticky completion status and level interrupt behind AXI-Lite.
module hpu_csr
    import hpu_csr_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter int          NCORE      = 1,
    parameter logic [19:0] DEF_ADDR_I = 20'd299,
    parameter logic [19:0] DEF_ADDR_J = 20'd2,
    parameter logic [15:0] DEF_RAND   = 16'd1000,
    parameter logic [31:0] VERSION    = 32'h0002_0000
) (
    input  logic             clk,
    input  logic             rst,
    hpu_csr_if.slave         s_axi,
    input  logic             get_fin,
    output logic             run,
    output logic             gen,
    output logic [15:0]      item_a,
    output logic [19:0]      addr_i,
    output logic [19:0]      addr_j,
    output logic [15:0]      random_num,
    output logic [NCORE-1:0] core_en,
    output logic             irq
);

    logic              wr_en, rd_en, wr_err, rd_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data, rd_data, rd_word, scratch;
    logic [3:0]        wr_strb;
    logic [4:0]        wr_off, rd_off;
    logic [2:0]        ctrl_w;
    logic              ie, done, gen_done, wr_hit, gen_term, unused;

    axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .s_axi   (s_axi),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_err  (rd_err),
        .wr_err  (wr_err)
    );

    // Only eight words exist; anything above 0x1C, including the top two address bits, is unmapped.
    assign wr_err = (wr_addr[ADDR_W-1:5] != '0);
    assign rd_err = (rd_addr[ADDR_W-1:5] != '0);
    assign wr_off = {wr_addr[4:2], 2'b00};
    assign rd_off = {rd_addr[4:2], 2'b00};
    assign wr_hit = wr_en && !wr_err;
    assign unused = ^{wr_addr[1:0], rd_addr[1:0]};

    assign ctrl_w   = 3'(strb_merge({29'b0, ie, run, gen}, wr_data, wr_strb));
    assign gen_term = gen && (item_a == random_num);
    assign irq      = ie && (done || gen_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            gen        <= 1'b0;
            run        <= 1'b0;
            ie         <= 1'b0;
            done       <= 1'b0;
            gen_done   <= 1'b0;
            item_a     <= '0;
            addr_i     <= DEF_ADDR_I;
            addr_j     <= DEF_ADDR_J;
            random_num <= DEF_RAND;
            core_en    <= '1;
            scratch    <= '0;
        end else begin
            // W1C first so that same-cycle hardware sets below take precedence.
            if (wr_hit && wr_off == OFF_STATUS && wr_strb[0]) begin
                if (wr_data[STAT_DONE])     done     <= 1'b0;
                if (wr_data[STAT_GEN_DONE]) gen_done <= 1'b0;
            end
            if (get_fin && run) done <= 1'b1;

            if (gen) begin
                if (gen_term) begin
                    gen      <= 1'b0;
                    gen_done <= 1'b1;
                    item_a   <= '0;
                end else if (item_a != 16'hFFFF) begin
                    item_a <= item_a + 16'd1;
                end
            end else begin
                item_a <= '0;
            end

            // Register writes last: a CTRL write overrides the gen auto-clear.
            if (wr_hit) begin
                case (wr_off)
                    OFF_CTRL: begin
                        gen <= ctrl_w[CTRL_GEN];
                        run <= ctrl_w[CTRL_RUN];
                        ie  <= ctrl_w[CTRL_IE];
                    end
                    OFF_ADDR_I:  addr_i     <= 20'(strb_merge({12'b0, addr_i}, wr_data, wr_strb));
                    OFF_ADDR_J:  addr_j     <= 20'(strb_merge({12'b0, addr_j}, wr_data, wr_strb));
                    OFF_RAND:    random_num <= 16'(strb_merge({16'b0, random_num}, wr_data, wr_strb));
                    OFF_CORE_EN: core_en    <= NCORE'(strb_merge(32'(core_en), wr_data, wr_strb));
                    OFF_SCRATCH: scratch    <= strb_merge(scratch, wr_data, wr_strb);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_off)
            OFF_CTRL: begin
                rd_word[CTRL_GEN] = gen;
                rd_word[CTRL_RUN] = run;
                rd_word[CTRL_IE]  = ie;
            end
            OFF_STATUS: begin
                rd_word[STAT_BUSY]     = run;
                rd_word[STAT_DONE]     = done;
                rd_word[STAT_GEN_DONE] = gen_done;
            end
            OFF_ADDR_I:  rd_word = {12'b0, addr_i};
            OFF_ADDR_J:  rd_word = {12'b0, addr_j};
            OFF_RAND:    rd_word = {16'b0, random_num};
            OFF_CORE_EN: rd_word = 32'(core_en);
            OFF_SCRATCH: rd_word = scratch;
            OFF_VERSION: rd_word = VERSION;
            default:     rd_word = '0;
        endcase
    end

    assign rd_data = (rd_en && !rd_err) ? rd_word : '0;

endmodule
